key_rx_fifo: RTL and testbench
==============================

KEY_RX_FIFO -- requirements
Module: key_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, sets the FIFO entry count; it SHALL be a power of two, 4..256.
REQ-002 Parameter IRQ_THRESH, default 1, sets the occupancy at which IRQ asserts; it SHALL be in the range 1..DEPTH.
REQ-003 Port CLK, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
REQ-004 Port RST_X, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port KEY_WE, input, 1 bit: byte strobe from the loader once the program load is done, one cycle per byte.
REQ-006 Port KEY_DATA, input, 8 bits: received byte, valid while KEY_WE=1.
REQ-007 Port RD_EN, input, 1 bit: CPU pop request for the head byte.
REQ-008 Port FLUSH, input, 1 bit: discard all entries.
REQ-009 Port OVF_CLR, input, 1 bit: clear the overflow flag.
REQ-010 Port RD_DATA, output, 8 bits: head byte.
REQ-011 Port RD_VALID, output, 1 bit: FIFO non-empty.
REQ-012 Port COUNT, output, log2(DEPTH)+1 bits: current occupancy.
REQ-013 Port OVF, output, 1 bit: sticky overflow flag (a byte was dropped).
REQ-014 Port IRQ, output, 1 bit: registered interrupt request.

Function
REQ-015 Push: KEY_WE=1 with COUNT<DEPTH SHALL write KEY_DATA at the write pointer, increment the write pointer modulo DEPTH, and increment COUNT.
REQ-016 Drop: KEY_WE=1 with COUNT==DEPTH and no accepted pop SHALL leave the FIFO unchanged and set OVF=1 on the next edge.
REQ-017 Pop: RD_EN=1 with COUNT>0 SHALL increment the read pointer modulo DEPTH and decrement COUNT.
REQ-018 RD_EN=1 with COUNT==0 SHALL be ignored, with no pointer change and no error flag.
REQ-019 Simultaneous push and pop with 0<COUNT<DEPTH SHALL move both pointers and leave COUNT unchanged.
REQ-020 Simultaneous push and pop at COUNT==DEPTH SHALL accept both, leave COUNT==DEPTH, and leave OVF unchanged.
REQ-021 Simultaneous push and pop at COUNT==0 SHALL accept the push only; there is no bypass path.
REQ-022 RD_DATA SHALL equal the entry at the read pointer whenever RD_VALID=1, and SHALL be first-word-fall-through.
REQ-023 RD_DATA and RD_VALID SHALL reflect a push into an empty FIFO one cycle after the KEY_WE edge.
REQ-024 RD_DATA SHALL be don't-care when RD_VALID=0.
REQ-025 RD_VALID SHALL equal (COUNT!=0), derived from registered state.
REQ-026 FLUSH=1 SHALL on the next edge zero both pointers and COUNT.
REQ-027 FLUSH SHALL take priority over a push or pop in the same cycle; that push is discarded and SHALL NOT set OVF.
REQ-028 OVF_CLR=1 SHALL clear OVF on the next edge.
REQ-029 A drop in the same cycle as OVF_CLR SHALL leave OVF=1; set wins.
REQ-030 FLUSH SHALL NOT clear OVF.
REQ-031 IRQ SHALL be registered as (next COUNT >= IRQ_THRESH) OR (next OVF), giving zero-cycle lag relative to COUNT and OVF.
REQ-032 Pointers SHALL be log2(DEPTH) bits with natural wrap-around.
REQ-033 COUNT SHALL be one bit wider than the pointers so that the full state is distinguishable.

Reset
REQ-034 RST_X=0 SHALL asynchronously force the read pointer, write pointer, COUNT, OVF, IRQ and RD_VALID to 0.
REQ-035 Storage contents SHALL NOT be reset.
REQ-036 Reset assertion mid-operation SHALL discard all entries.
REQ-037 Deassertion of RST_X SHALL be taken synchronously; the first push SHALL be accepted on the first edge after deassertion.

Structure
REQ-038 The shared package SHALL hold KEY_FIFO_DEPTH (16), KEY_DATA_W (8) and the KEY_FIFO_AW derivation.
REQ-039 The block SHALL be a single module with storage inferred as distributed RAM; no sub-module is required.

Verification
REQ-040 Reset, then push 0x41, 0x42, 0x43 on consecutive cycles -> COUNT=3, RD_DATA=0x41, IRQ=1; three pops -> 0x41, 0x42, 0x43 in order, then RD_VALID=0 and IRQ=0.
REQ-041 Push 17 bytes 0x00..0x10 with no pops -> COUNT=16, OVF=1, byte 0x10 dropped; 16 pops -> 0x00..0x0F; OVF_CLR -> OVF=0.
REQ-042 Fill to 16, then push 0x99 and pop in the same cycle -> COUNT=16, OVF=0, and the last byte popped after draining is 0x99.
REQ-043 Empty FIFO, push 0x55 with RD_EN=1 in the same cycle -> COUNT=1, RD_DATA=0x55 next cycle; RD_EN on empty -> COUNT stays 0.
REQ-044 Fill 20 entries with pops interleaved to force pointer wrap past 15 -> no data corruption; FLUSH with a simultaneous push -> COUNT=0 and OVF unchanged.
REQ-045 Assert RST_X=0 asynchronously with COUNT=5 and OVF=1 -> COUNT, OVF, IRQ and RD_VALID read 0 before the next CLK edge.

Source files
------------

// File: rtl/key_rx_fifo_pkg.sv
// key_rx_fifo_pkg: shared sizing constants for the key receive FIFO
package key_rx_fifo_pkg;

    localparam int KEY_FIFO_DEPTH = 16;
    localparam int KEY_DATA_W     = 8;

    function automatic int key_fifo_aw(input int depth);
        return $clog2(depth);
    endfunction

    localparam int KEY_FIFO_AW = key_fifo_aw(KEY_FIFO_DEPTH);

endpackage

// File: rtl/key_rx_fifo.sv
// key_rx_fifo: first-word-fall-through byte FIFO between the key loader and the CPU
module key_rx_fifo
    import key_rx_fifo_pkg::*;
#(
    parameter int  DEPTH      = KEY_FIFO_DEPTH,
    parameter int  IRQ_THRESH = 1,
    localparam int AW         = key_fifo_aw(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RST_X,
    input  logic                  KEY_WE,
    input  logic [KEY_DATA_W-1:0] KEY_DATA,
    input  logic                  RD_EN,
    input  logic                  FLUSH,
    input  logic                  OVF_CLR,
    output logic [KEY_DATA_W-1:0] RD_DATA,
    output logic                  RD_VALID,
    output logic [AW:0]           COUNT,
    output logic                  OVF,
    output logic                  IRQ
);

    localparam logic [AW:0] FULL   = (AW+1)'(DEPTH);
    localparam logic [AW:0] THRESH = (AW+1)'(IRQ_THRESH);

    logic [KEY_DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]         rptr_q, rptr_d, wptr_q, wptr_d;
    logic [AW:0]           cnt_q, cnt_d;
    logic                  ovf_q, ovf_d, irq_q, irq_d;
    logic                  pop_ok, push_ok, drop;

    // Accept/drop decisions; a pop frees room for a push when full, flush overrides both but leaves OVF alone
    always_comb begin
        pop_ok  = RD_EN && cnt_q != '0;
        push_ok = KEY_WE && (cnt_q != FULL || pop_ok) && !FLUSH;
        drop    = KEY_WE && cnt_q == FULL && !pop_ok && !FLUSH;
        rptr_d  = FLUSH ? '0 : rptr_q + AW'(pop_ok);
        wptr_d  = FLUSH ? '0 : wptr_q + AW'(push_ok);
        cnt_d   = FLUSH ? '0 : cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        ovf_d   = drop || (ovf_q && !OVF_CLR);
        irq_d   = cnt_d >= THRESH || ovf_d;
    end

    // Control state; reset empties the FIFO but leaves storage untouched
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            irq_q  <= irq_d;
        end
    end

    // Storage write port, kept reset-free so it maps onto distributed RAM
    always_ff @(posedge CLK) begin
        if (push_ok) mem[wptr_q] <= KEY_DATA;
    end

    assign RD_DATA  = mem[rptr_q];
    assign RD_VALID = cnt_q != '0;
    assign COUNT    = cnt_q;
    assign OVF      = ovf_q;
    assign IRQ      = irq_q;

endmodule

// File: tb/tb_key_rx_fifo.sv
// tb_key_rx_fifo: directed and randomized checks of key_rx_fifo against a queue model
module tb_key_rx_fifo;

    logic       CLK = 1'b0, RST_X = 1'b0;
    logic       KEY_WE = 1'b0, RD_EN = 1'b0, FLUSH = 1'b0, OVF_CLR = 1'b0;
    logic [7:0] KEY_DATA = 8'h00;
    logic [7:0] RD_DATA;
    logic       RD_VALID, OVF, IRQ;
    logic [4:0] COUNT;

    int          n_chk = 0, n_pass = 0;
    byte unsigned q[$];
    bit          m_ovf = 1'b0;
    byte unsigned last;

    always #5 CLK = ~CLK;

    key_rx_fifo dut (
        .CLK(CLK), .RST_X(RST_X), .KEY_WE(KEY_WE), .KEY_DATA(KEY_DATA),
        .RD_EN(RD_EN), .FLUSH(FLUSH), .OVF_CLR(OVF_CLR),
        .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .COUNT(COUNT), .OVF(OVF), .IRQ(IRQ)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".count"}, int'(COUNT), q.size());
        check({tag, ".valid"}, int'(RD_VALID), int'(q.size() != 0));
        check({tag, ".ovf"}, int'(OVF), int'(m_ovf));
        check({tag, ".irq"}, int'(IRQ), int'(q.size() >= 1 || m_ovf));
        if (q.size() != 0) check({tag, ".data"}, int'(RD_DATA), int'(q[0]));
    endtask

    task automatic model(input bit we, input byte unsigned d, input bit rd, input bit fl, input bit oc);
        bit pop, drop;
        pop  = rd && q.size() > 0;
        drop = we && q.size() == 16 && !pop && !fl;
        if (fl) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (we && !drop) q.push_back(d);
        end
        if (drop) m_ovf = 1'b1;
        else if (oc) m_ovf = 1'b0;
    endtask

    task automatic step(input bit we, input byte unsigned d, input bit rd, input bit fl, input bit oc, input string tag);
        KEY_WE = we; KEY_DATA = d; RD_EN = rd; FLUSH = fl; OVF_CLR = oc;
        @(posedge CLK);
        #1;
        KEY_WE = 1'b0; RD_EN = 1'b0; FLUSH = 1'b0; OVF_CLR = 1'b0;
        model(we, d, rd, fl, oc);
        compare_all(tag);
    endtask

    task automatic fill(input byte unsigned base, input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b1, 8'(int'(base) + i), 1'b0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        #1;
        compare_all("reset");
        #11 RST_X = 1'b1;

        fill(8'h41, 3, "r40.push");
        check("r40.count", int'(COUNT), 3);
        check("r40.head", int'(RD_DATA), 'h41);
        check("r40.irq", int'(IRQ), 1);
        for (int i = 0; i < 3; i++) begin
            check("r40.order", int'(RD_DATA), 'h41 + i);
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "r40.pop");
        end
        check("r40.valid_end", int'(RD_VALID), 0);
        check("r40.irq_end", int'(IRQ), 0);

        fill(8'h00, 17, "r41.push");
        check("r41.count", int'(COUNT), 16);
        check("r41.ovf", int'(OVF), 1);
        for (int i = 0; i < 16; i++) begin
            check("r41.order", int'(RD_DATA), i);
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "r41.pop");
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "r41.clr");
        check("r41.ovf_clr", int'(OVF), 0);

        fill(8'h80, 16, "r42.fill");
        step(1'b1, 8'h99, 1'b1, 1'b0, 1'b0, "r42.pushpop");
        check("r42.count", int'(COUNT), 16);
        check("r42.ovf", int'(OVF), 0);
        last = 8'h00;
        for (int i = 0; i < 16; i++) begin
            last = RD_DATA;
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "r42.drain");
        end
        check("r42.last", int'(last), 'h99);

        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, "r43.push_empty");
        check("r43.count", int'(COUNT), 1);
        check("r43.data", int'(RD_DATA), 'h55);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "r43.pop");
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "r43.pop_empty");
        check("r43.count_empty", int'(COUNT), 0);

        for (int i = 0; i < 20; i++) step(1'b1, 8'(8'hA0 + i), i % 2 == 1, 1'b0, 1'b0, "r44.wrap");
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "r44.drain");
        fill(8'hC0, 16, "r44.fill");
        step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, "r44.flush_push");
        check("r44.flush_count", int'(COUNT), 0);
        check("r44.flush_ovf0", int'(OVF), 0);
        fill(8'hD0, 17, "r44.fill_ovf");
        step(1'b1, 8'hEF, 1'b0, 1'b1, 1'b0, "r44.flush_keep");
        check("r44.flush_ovf1", int'(OVF), 1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "r44.clr");

        fill(8'h10, 17, "r45.fill");
        for (int i = 0; i < 11; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "r45.pop");
        check("r45.pre_count", int'(COUNT), 5);
        check("r45.pre_ovf", int'(OVF), 1);
        @(posedge CLK);
        #2 RST_X = 1'b0;
        #1;
        check("r45.count", int'(COUNT), 0);
        check("r45.ovf", int'(OVF), 0);
        check("r45.irq", int'(IRQ), 0);
        check("r45.valid", int'(RD_VALID), 0);
        q.delete();
        m_ovf = 1'b0;
        #4 RST_X = 1'b1;
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, "r45.first_push");
        check("r45.first_count", int'(COUNT), 1);

        for (int i = 0; i < 3000; i++) begin
            int ph, wp, rp;
            ph = (i / 200) % 3;
            wp = ph == 0 ? 90 : ph == 1 ? 50 : 20;
            rp = ph == 0 ? 15 : ph == 1 ? 50 : 85;
            step($urandom_range(99) < wp, 8'($urandom), $urandom_range(99) < rp,
                 $urandom_range(99) < 2, $urandom_range(99) < 5, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
